// File: rtl/fetch_realign_queue.sv
// Splits aligned 32-bit fetch words into 16/32-bit instructions, stitches straddlers, queues them for decode.
// Latency: an entry pushed in cycle N is visible at the head in N+1; fetch is stalled when fewer than two slots are free.
module fetch_realign_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned VLEN  = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic [VLEN-1:0]            fetch_addr_i,
    input  logic [31:0]                fetch_data_i,
    input  logic                       fetch_ex_i,
    output logic                       fetch_entry_valid_o,
    input  logic                       fetch_entry_ready_i,
    output logic [31:0]                fetch_entry_instr_o,
    output logic [VLEN-1:0]            fetch_entry_addr_o,
    output logic                       fetch_entry_ex_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]     instr_q [DEPTH];
    logic [VLEN-1:0] addr_q  [DEPTH];
    logic            ex_q    [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic            pend_vld_q, pend_vld_n;
    logic [15:0]     pend_dat_q, pend_dat_n;
    logic [VLEN-1:0] pend_addr_q, pend_addr_n;

    logic            push, pop, use_hw1;
    logic [1:0]      n_emit;
    logic [31:0]     e_instr [2];
    logic [VLEN-1:0] e_addr  [2];
    logic            e_ex    [2];
    logic [VLEN-1:0] hw1_addr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fetch_ready_o       = !flush_i && (count_q <= CW'(DEPTH - 2));
    assign fetch_entry_valid_o = (count_q != '0);
    assign fetch_entry_instr_o = instr_q[rd_ptr_q];
    assign fetch_entry_addr_o  = addr_q[rd_ptr_q];
    assign fetch_entry_ex_o    = ex_q[rd_ptr_q];
    assign count_o             = count_q;

    assign push     = fetch_valid_i && fetch_ready_o;
    assign pop      = fetch_entry_valid_o && fetch_entry_ready_i;
    assign hw1_addr = {fetch_addr_i[VLEN-1:2], 2'b10};

    // Realignment: up to two entries per fetch word, in program order.
    always_comb begin
        n_emit      = 2'd0;
        use_hw1     = 1'b0;
        pend_vld_n  = pend_vld_q;
        pend_dat_n  = pend_dat_q;
        pend_addr_n = pend_addr_q;
        for (int i = 0; i < 2; i++) begin
            e_instr[i] = '0;
            e_addr[i]  = '0;
            e_ex[i]    = 1'b0;
        end

        if (fetch_ex_i) begin
            e_ex[0]    = 1'b1;
            e_addr[0]  = pend_vld_q ? pend_addr_q : fetch_addr_i;
            n_emit     = 2'd1;
            pend_vld_n = 1'b0;
        end else begin
            if (pend_vld_q) begin
                e_instr[0] = {fetch_data_i[15:0], pend_dat_q};
                e_addr[0]  = pend_addr_q;
                n_emit     = 2'd1;
                pend_vld_n = 1'b0;
                use_hw1    = 1'b1;
            end else if (!fetch_addr_i[1]) begin
                e_addr[0] = fetch_addr_i;
                n_emit    = 2'd1;
                if (fetch_data_i[1:0] != 2'b11) begin
                    e_instr[0] = {16'b0, fetch_data_i[15:0]};
                    use_hw1    = 1'b1;
                end else begin
                    e_instr[0] = fetch_data_i;
                end
            end else begin
                use_hw1 = 1'b1;
            end

            if (use_hw1) begin
                if (fetch_data_i[17:16] != 2'b11) begin
                    e_instr[n_emit[0]] = {16'b0, fetch_data_i[31:16]};
                    e_addr[n_emit[0]]  = hw1_addr;
                    n_emit             = n_emit + 2'd1;
                end else begin
                    pend_vld_n  = 1'b1;
                    pend_dat_n  = fetch_data_i[31:16];
                    pend_addr_n = hw1_addr;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pend_vld_q  <= 1'b0;
            pend_dat_q  <= '0;
            pend_addr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                addr_q[i]  <= '0;
                ex_q[i]    <= 1'b0;
            end
        end else if (flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            if (push) begin
                if (n_emit != 2'd0) begin
                    instr_q[wr_ptr_q] <= e_instr[0];
                    addr_q[wr_ptr_q]  <= e_addr[0];
                    ex_q[wr_ptr_q]    <= e_ex[0];
                end
                if (n_emit == 2'd2) begin
                    instr_q[ptr_inc(wr_ptr_q)] <= e_instr[1];
                    addr_q[ptr_inc(wr_ptr_q)]  <= e_addr[1];
                    ex_q[ptr_inc(wr_ptr_q)]    <= e_ex[1];
                end
                case (n_emit)
                    2'd1:    wr_ptr_q <= ptr_inc(wr_ptr_q);
                    2'd2:    wr_ptr_q <= ptr_inc(ptr_inc(wr_ptr_q));
                    default: wr_ptr_q <= wr_ptr_q;
                endcase
                pend_vld_q  <= pend_vld_n;
                pend_dat_q  <= pend_dat_n;
                pend_addr_q <= pend_addr_n;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + (push ? CW'(n_emit) : CW'(0)) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (count_q <= CW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_fetch_realign_queue.sv
// Directed bench for fetch_realign_queue: hand-computed entries, backpressure, flush, fault and reset.
module tb_fetch_realign_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned VLEN  = 64;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            flush_i = 1'b0;
    logic            fetch_valid_i = 1'b0;
    logic            fetch_ready_o;
    logic [VLEN-1:0] fetch_addr_i = '0;
    logic [31:0]     fetch_data_i = '0;
    logic            fetch_ex_i = 1'b0;
    logic            fetch_entry_valid_o;
    logic            fetch_entry_ready_i = 1'b0;
    logic [31:0]     fetch_entry_instr_o;
    logic [VLEN-1:0] fetch_entry_addr_o;
    logic            fetch_entry_ex_o;
    logic [2:0]      count_o;

    int total = 0;
    int bad   = 0;

    fetch_realign_queue #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .flush_i             (flush_i),
        .fetch_valid_i       (fetch_valid_i),
        .fetch_ready_o       (fetch_ready_o),
        .fetch_addr_i        (fetch_addr_i),
        .fetch_data_i        (fetch_data_i),
        .fetch_ex_i          (fetch_ex_i),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_entry_ready_i (fetch_entry_ready_i),
        .fetch_entry_instr_o (fetch_entry_instr_o),
        .fetch_entry_addr_o  (fetch_entry_addr_o),
        .fetch_entry_ex_o    (fetch_entry_ex_o),
        .count_o             (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] a, input logic [31:0] d, input logic ex);
        fetch_valid_i = 1'b1;
        fetch_addr_i  = a;
        fetch_data_i  = d;
        fetch_ex_i    = ex;
        @(posedge clk_i);
        #1;
        fetch_valid_i = 1'b0;
        fetch_ex_i    = 1'b0;
    endtask

    task automatic pop();
        fetch_entry_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        fetch_entry_ready_i = 1'b0;
    endtask

    task automatic head(input string tag, input logic [31:0] instr, input logic [63:0] a, input logic ex);
        chk({tag, ".valid"}, 64'(fetch_entry_valid_o), 64'(1));
        chk({tag, ".instr"}, 64'(fetch_entry_instr_o), 64'(instr));
        chk({tag, ".addr"}, fetch_entry_addr_o, a);
        chk({tag, ".ex"}, 64'(fetch_entry_ex_o), 64'(ex));
        pop();
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("rst.count", 64'(count_o), 64'(0));
        chk("rst.valid", 64'(fetch_entry_valid_o), 64'(0));
        chk("rst.ready", 64'(fetch_ready_o), 64'(1));
        chk("rst.instr", 64'(fetch_entry_instr_o), 64'(0));
        chk("rst.addr", fetch_entry_addr_o, 64'(0));

        // Two compressed instructions in one word
        push(64'h8000_0000, 32'h0001_0001, 1'b0);
        chk("cc.count", 64'(count_o), 64'(2));
        head("cc0", 32'h0000_0001, 64'h8000_0000, 1'b0);
        head("cc1", 32'h0000_0001, 64'h8000_0002, 1'b0);
        chk("cc.empty", 64'(count_o), 64'(0));

        // Straddling 32-bit instruction
        push(64'h1000, 32'h0013_4501, 1'b0);
        chk("st.count1", 64'(count_o), 64'(1));
        push(64'h1004, 32'h0000_0000, 1'b0);
        chk("st.count2", 64'(count_o), 64'(3));
        head("st0", 32'h0000_4501, 64'h1000, 1'b0);
        head("st1", 32'h0000_0013, 64'h1002, 1'b0);
        head("st2", 32'h0000_0000, 64'h1006, 1'b0);

        // Jump target into upper halfword
        push(64'h2002, 32'h0001_FFFF, 1'b0);
        chk("jt.count", 64'(count_o), 64'(1));
        head("jt0", 32'h0000_0001, 64'h2002, 1'b0);
        push(64'h2002, 32'h0013_FFFF, 1'b0);
        chk("jt.pend_count", 64'(count_o), 64'(0));
        chk("jt.pend_valid", 64'(fetch_entry_valid_o), 64'(0));
        push(64'h2004, 32'h0000_0000, 1'b0);
        chk("jt.count2", 64'(count_o), 64'(2));
        head("jt1", 32'h0000_0013, 64'h2002, 1'b0);
        head("jt2", 32'h0000_0000, 64'h2006, 1'b0);

        // Backpressure: ready depends on registered count only
        push(64'h4000, 32'h0001_0001, 1'b0);
        push(64'h4004, 32'h0001_0001, 1'b0);
        chk("bp.count4", 64'(count_o), 64'(4));
        chk("bp.ready0", 64'(fetch_ready_o), 64'(0));
        pop();
        chk("bp.count3", 64'(count_o), 64'(3));
        chk("bp.ready_still0", 64'(fetch_ready_o), 64'(0));
        pop();
        chk("bp.count2", 64'(count_o), 64'(2));
        chk("bp.ready1", 64'(fetch_ready_o), 64'(1));

        // Fill with pending set, then flush
        push(64'h5000, 32'h0013_0001, 1'b0);
        chk("fl.count3", 64'(count_o), 64'(3));
        flush_i = 1'b1;
        chk("fl.ready_low", 64'(fetch_ready_o), 64'(0));
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        chk("fl.count0", 64'(count_o), 64'(0));
        chk("fl.valid0", 64'(fetch_entry_valid_o), 64'(0));
        push(64'h3000, 32'h0000_0013, 1'b0);
        chk("fl.count1", 64'(count_o), 64'(1));
        head("fl0", 32'h0000_0013, 64'h3000, 1'b0);

        // Fetch fault while pending is valid
        push(64'h1000, 32'h0013_0001, 1'b0);
        push(64'h1004, 32'hDEAD_BEEF, 1'b1);
        chk("ex.count", 64'(count_o), 64'(2));
        head("ex0", 32'h0000_0001, 64'h1000, 1'b0);
        head("ex1", 32'h0000_0000, 64'h1002, 1'b1);
        push(64'h1008, 32'h0000_0013, 1'b0);
        chk("ex.nopend_count", 64'(count_o), 64'(1));
        head("ex2", 32'h0000_0013, 64'h1008, 1'b0);

        // Simultaneous push and pop
        push(64'h6000, 32'h0001_0001, 1'b0);
        fetch_entry_ready_i = 1'b1;
        push(64'h6004, 32'h0001_0001, 1'b0);
        fetch_entry_ready_i = 1'b0;
        chk("pp.count3", 64'(count_o), 64'(3));
        head("pp0", 32'h0000_0001, 64'h6002, 1'b0);

        // Reset mid-stream
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("mr.count", 64'(count_o), 64'(0));
        chk("mr.valid", 64'(fetch_entry_valid_o), 64'(0));
        chk("mr.ready", 64'(fetch_ready_o), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_realign_queue.md
Name: fetch_realign_queue

Overview:
- Sits directly upstream of the decode stage.
- Accepts 32-bit aligned fetch words from the frontend, splits them into individual 16-bit (compressed) or 32-bit instructions, and stitches 32-bit instructions that straddle two fetch words.
- Buffers the results in a small FIFO that drives the decode stage's fetch-entry valid/ready handshake, one instruction per cycle.

Parameters:
- DEPTH, 4: output FIFO entries; must be >= 2.
- VLEN, 64: virtual address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  discard all buffered state
- fetch_valid_i  in  1  fetch word valid
- fetch_ready_o  out  1  fetch word accepted when high with fetch_valid_i
- fetch_addr_i  in  VLEN  address of first useful halfword; bit[1]=1 means the lower half is discarded (jump target)
- fetch_data_i  in  32  fetch word, halfword 0 in [15:0]
- fetch_ex_i  in  1  fetch fault on this word
- fetch_entry_valid_o  out  1  head entry valid
- fetch_entry_ready_i  in  1  decode accepts head entry
- fetch_entry_instr_o  out  32  instruction; compressed instructions zero-extended
- fetch_entry_addr_o  out  VLEN  instruction address
- fetch_entry_ex_o  out  1  entry carries a fetch fault
- count_o  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset and clock: one clock, synchronous active-high reset rst_i.
- Reset values:
  - count_o = 0, all entries 0, pending halfword invalid.
  - fetch_entry_valid_o = 0, fetch_ready_o = 1.
  - Reset mid-operation drops everything on the next edge.
- Compressed test: a halfword is compressed iff bits[1:0] != 2'b11.
- fetch_ready_o = !flush_i && (DEPTH - count_q) >= 2. It depends on registered count only; a same-cycle pop does not free space.
- Push on fetch_valid_i && fetch_ready_o. Entries are produced in order, at most 2 per push:
  - Start: if pending valid, emit {data[15:0], pending.data} at pending.addr and clear pending. Halfword 0 is then consumed; continue with halfword 1.
  - Else if addr[1]=0: if halfword 0 is compressed, emit {16'b0, data[15:0]} at addr and continue with halfword 1; otherwise emit data[31:0] at addr (word fully consumed).
  - Else (addr[1]=1): continue with halfword 1 at {addr[VLEN-1:2], 2'b10}.
  - Halfword 1: if compressed, emit {16'b0, data[31:16]} at addr_base+2; otherwise store it as pending with that address.
- Fetch fault (fetch_ex_i=1): push exactly one entry with instr=0, ex=1. addr = pending.addr if pending valid, else fetch_addr_i. Pending is cleared.
- No contiguity check: a word arriving while pending is valid is contiguous by contract. Upstream must flush on redirect.
- Pop on fetch_entry_valid_o && fetch_entry_ready_i; head advances.
- Output timing:
  - fetch_entry_valid_o = (count_q != 0).
  - Head outputs are registered FIFO contents.
  - A push in cycle N is visible at the output no earlier than N+1.
- Simultaneous push and pop allowed: count_n = count_q + pushed - popped. Pointers wrap modulo DEPTH.
- Overflow is impossible by construction; assert count_q <= DEPTH.
- Flush: on the next edge count=0, pointers=0, pending invalid. Any same-cycle push is ignored (ready is low). A same-cycle pop is irrelevant. flush_i has priority over everything except rst_i.

Test Plan:
- Two compressed instructions, one word: addr 0x80000000, data 0x00010001 -> entries (0x00000001 @0x80000000) then (0x00000001 @0x80000002); count_o=2.
- Straddling instruction: word 0x00134501 @0x1000, then 0x00000000 @0x1004 -> entries 0x00004501 @0x1000, 0x00000013 @0x1002, 0x00000000 @0x1006.
- Jump target: addr 0x2002, data 0x0001FFFF -> single entry 0x00000001 @0x2002. With data 0x0013FFFF instead: no entry, pending set; next word 0x00000000 @0x2004 -> 0x00000013 @0x2002.
- Backpressure (DEPTH=4, fetch_entry_ready_i=0): push 0x00010001 twice -> count_o=4, fetch_ready_o=0. One pop -> count 3, ready stays 0. Second pop -> ready 1.
- Flush with full queue and pending valid: pulse flush_i -> next cycle count_o=0, valid=0. Then 0x00000013 @0x3000 -> single entry 0x00000013 @0x3000 (no stale pending).
- Fault: pending set @0x1002, then fetch_ex_i=1 @0x1004 -> one entry ex=1, instr=0, addr 0x1002, pending cleared. Assert rst_i mid-stream -> count_o=0 on the next edge.
